// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   UART-driven initiator for the 12-bit register bus.
//   - Byte commands arrive on uart_rx_i (8N1).
//   - Each accepted command issues one register_read_o or register_write_o strobe.
//   - Responses go out on uart_tx_o.
//   Commands:
//     'W' IH IL VH VL  write, answered with 'K'
//     'R' IH IL        read, answered with 'D' VH VL
//     any other opcode answered with '?'
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     uart_rx_i / uart_tx_o   serial in / out, idle high
//     register_index_o        12-bit register address, held until next command
//     register_read_o         one-cycle read strobe
//     register_write_o        one-cycle write strobe
//     register_write_value_o  16-bit write data
//     register_read_value_i   16-bit read data, valid READ_LATENCY cycles after strobe
//     bridge_active_o         high from opcode byte until response stop bit ends
//   Optional feature, enabled by defining UART_REG_BRIDGE_TIMEOUT_EN:
//     an inter-byte timeout of TIMEOUT_CYCLES aborts a partial command and
//     answers 'T'.
module uart_reg_bridge #(
  parameter int unsigned CLKS_PER_BIT   = 217,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [11:0] register_index_o,
  output logic        register_read_o,
  output logic        register_write_o,
  output logic [15:0] register_write_value_o,
  input  logic [15:0] register_read_value_i,
  output logic        bridge_active_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0]    WAIT_LAST = 2'(READ_LATENCY - 1);

  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, RSP_K = 8'h4B;
  localparam logic [7:0] RSP_D = 8'h44, RSP_Q = 8'h3F, RSP_T = 8'h54;

  if (CLKS_PER_BIT < 4 || READ_LATENCY < 1 || READ_LATENCY > 3 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("uart_reg_bridge: parameter out of range");
  end

  // ---------------- RX ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t     rx_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= uart_rx_i;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- TX ----------------
  // Loads up to three bytes at once; the next frame starts on the cycle after
  // the previous stop bit, so multi-byte responses have no idle gap.
  logic          tx_start;
  logic [1:0]    tx_len;
  logic [23:0]   tx_data;
  logic          tx_busy, tx_out, tx_last_done;
  logic [9:0]    tx_frame;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic [15:0]   tx_queue;
  logic [1:0]    tx_left;

  assign tx_last_done = tx_busy && tx_cnt == BIT_LAST && tx_bit == 4'd9 && tx_left == 2'd0;
  assign uart_tx_o    = tx_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy  <= 1'b0;
      tx_out   <= 1'b1;
      tx_frame <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      tx_queue <= '0;
      tx_left  <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        tx_frame <= {1'b1, tx_data[23:16], 1'b0};
        tx_queue <= tx_data[15:0];
        tx_left  <= tx_len - 2'd1;
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_out   <= 1'b0;
      end
    end else if (tx_cnt != BIT_LAST) begin
      tx_cnt <= tx_cnt + CW'(1);
    end else begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        if (tx_left != 2'd0) begin
          tx_frame <= {1'b1, tx_queue[15:8], 1'b0};
          tx_queue <= {tx_queue[7:0], 8'h00};
          tx_left  <= tx_left - 2'd1;
          tx_bit   <= '0;
          tx_out   <= 1'b0;
        end else begin
          tx_busy <= 1'b0;
          tx_out  <= 1'b1;
        end
      end else begin
        tx_bit   <= tx_bit + 4'd1;
        tx_frame <= {1'b1, tx_frame[9:1]};
        tx_out   <= tx_frame[1];
      end
    end
  end

  // ---------------- Command parser ----------------
  typedef enum logic [2:0] {IDLE, GET_IH, GET_IL, GET_VH, GET_VL, ISSUE, WAIT_RD, RESP} state_t;
  state_t     state, next;
  logic       is_write, is_cmd, timeout;
  logic [1:0] wait_cnt;

  assign is_cmd = (rx_byte == OP_W) || (rx_byte == OP_R);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          in_get;

  assign in_get  = state inside {GET_IH, GET_IL, GET_VH, GET_VL};
  assign timeout = in_get && to_cnt == TW'(TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                to_cnt <= '0;
    else if (!in_get || rx_valid) to_cnt <= '0;
    else if (!timeout)           to_cnt <= to_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (rx_valid && is_cmd) next = GET_IH;
      GET_IH:  if (rx_valid) next = GET_IL; else if (timeout) next = IDLE;
      GET_IL:  if (rx_valid) next = is_write ? GET_VH : ISSUE; else if (timeout) next = IDLE;
      GET_VH:  if (rx_valid) next = GET_VL; else if (timeout) next = IDLE;
      GET_VL:  if (rx_valid) next = ISSUE;  else if (timeout) next = IDLE;
      ISSUE:   next = is_write ? RESP : WAIT_RD;
      WAIT_RD: if (wait_cnt == WAIT_LAST) next = RESP;
      RESP:    if (tx_last_done) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Read data is taken straight into the TX buffer on the last wait edge,
  // which makes that edge both the capture point and the response start.
  always_comb begin
    register_write_o = (state == ISSUE) && is_write;
    register_read_o  = (state == ISSUE) && !is_write;
    bridge_active_o  = (state != IDLE);
    tx_start = 1'b0;
    tx_len   = 2'd0;
    tx_data  = '0;
    case (state)
      IDLE: if (rx_valid && !is_cmd) begin
        tx_start = 1'b1; tx_len = 2'd1; tx_data = {RSP_Q, 16'h0000};
      end
      GET_IH, GET_IL, GET_VH, GET_VL: if (!rx_valid && timeout) begin
        tx_start = 1'b1; tx_len = 2'd1; tx_data = {RSP_T, 16'h0000};
      end
      ISSUE: if (is_write) begin
        tx_start = 1'b1; tx_len = 2'd1; tx_data = {RSP_K, 16'h0000};
      end
      WAIT_RD: if (wait_cnt == WAIT_LAST) begin
        tx_start = 1'b1; tx_len = 2'd3; tx_data = {RSP_D, register_read_value_i};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_write               <= 1'b0;
      register_index_o       <= '0;
      register_write_value_o <= '0;
      wait_cnt               <= '0;
    end else begin
      case (state)
        IDLE:    if (rx_valid && is_cmd) is_write <= (rx_byte == OP_W);
        GET_IH:  if (rx_valid) register_index_o[11:8]       <= rx_byte[3:0];
        GET_IL:  if (rx_valid) register_index_o[7:0]        <= rx_byte;
        GET_VH:  if (rx_valid) register_write_value_o[15:8] <= rx_byte;
        GET_VL:  if (rx_valid) register_write_value_o[7:0]  <= rx_byte;
        ISSUE:   wait_cnt <= '0;
        WAIT_RD: wait_cnt <= wait_cnt + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;
  localparam int BIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        uart_tx_o;
  logic [11:0] register_index_o;
  logic        register_read_o, register_write_o;
  logic [15:0] register_write_value_o;
  logic [15:0] register_read_value_i = 16'h0000;
  logic        bridge_active_o;

  uart_reg_bridge #(.CLKS_PER_BIT(BIT), .READ_LATENCY(1), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .register_index_o(register_index_o), .register_read_o(register_read_o),
    .register_write_o(register_write_o), .register_write_value_o(register_write_value_o),
    .register_read_value_i(register_read_value_i), .bridge_active_o(bridge_active_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: latency 1, 0x00A5 at index 0x002, 0xC0DE elsewhere.
  always @(posedge clk)
    if (register_read_o)
      register_read_value_i <= (register_index_o == 12'h002) ? 16'h00A5 : 16'hC0DE;

  // Strobe and bridge_active monitor
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, wr_cyc = 0, rd_cyc = 0, ba_fall = 0;
  logic [11:0] wr_idx = '0, rd_idx = '0;
  logic [15:0] wr_val = '0;
  logic        ba_prev = 1'b0;
  always @(negedge clk) begin
    if (register_write_o) begin
      wr_cnt++; wr_idx = register_index_o; wr_val = register_write_value_o; wr_cyc = cyc;
    end
    if (register_read_o) begin
      rd_cnt++; rd_idx = register_index_o; rd_cyc = cyc;
    end
    if (register_write_o && register_read_o) both_cnt++;
    if (ba_prev && !bridge_active_o) ba_fall = cyc;
    ba_prev = bridge_active_o;
  end

  // TX decoder: start-bit cycle and byte of every frame
  logic [7:0] tx_q[$];
  int         tx_t[$];
  initial begin
    logic [7:0] b;
    int t;
    forever begin
      @(negedge clk);
      if (uart_tx_o === 1'b0) begin
        t = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_tx_o;
        end
        repeat (BIT) @(negedge clk);
        tx_q.push_back(b);
        tx_t.push_back(t);
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx_i = stop;
    repeat (BIT) @(negedge clk);
    uart_rx_i = 1'b1;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bridge_active_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bridge_active_o), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_tx();
    tx_q.delete();
    tx_t.delete();
  endtask

  int w0, r0;

  initial begin
    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(uart_tx_o), 32'd1);
    chk("rst_wr", 32'(register_write_o), 32'd0);
    chk("rst_rd", 32'(register_read_o), 32'd0);
    chk("rst_idx", 32'(register_index_o), 32'h0);
    chk("rst_val", 32'(register_write_value_o), 32'h0);
    chk("rst_active", 32'(bridge_active_o), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0x123 <= 0xBEEF
    clear_tx(); w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h57, 1'b1);
    repeat (4) @(negedge clk);
    chk("wr_active_after_op", 32'(bridge_active_o), 32'd1);
    send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    wait_tx(1, "wr_resp_wait");
    wait_idle("wr_idle_wait");
    chk("wr_count", 32'(wr_cnt - w0), 32'd1);
    chk("wr_no_read", 32'(rd_cnt - r0), 32'd0);
    chk("wr_idx", 32'(wr_idx), 32'h123);
    chk("wr_val", 32'(wr_val), 32'hBEEF);
    chk("wr_resp", 32'(tx_q[0]), 32'h4B);
    chk("wr_latency", 32'(tx_t[0] - wr_cyc), 32'd1);
    chk("wr_active_fall", 32'(ba_fall - tx_t[0]), 32'd40);
    chk("wr_idx_hold", 32'(register_index_o), 32'h123);

    // Read 0x002 (IH upper nibble ignored)
    clear_tx(); w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h52, 1'b1); send_byte(8'hF0, 1'b1); send_byte(8'h02, 1'b1);
    wait_tx(3, "rd_resp_wait");
    wait_idle("rd_idle_wait");
    chk("rd_count", 32'(rd_cnt - r0), 32'd1);
    chk("rd_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rd_idx", 32'(rd_idx), 32'h002);
    chk("rd_b0", 32'(tx_q[0]), 32'h44);
    chk("rd_b1", 32'(tx_q[1]), 32'h00);
    chk("rd_b2", 32'(tx_q[2]), 32'hA5);
    chk("rd_latency", 32'(tx_t[0] - rd_cyc), 32'd2);
    chk("rd_gap1", 32'(tx_t[1] - tx_t[0]), 32'd40);
    chk("rd_gap2", 32'(tx_t[2] - tx_t[1]), 32'd40);

    // Unknown opcode, then a normal read
    clear_tx(); w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h41, 1'b1);
    repeat (4) @(negedge clk);
    chk("bad_op_active", 32'(bridge_active_o), 32'd0);
    wait_tx(1, "bad_op_wait");
    repeat (6) @(negedge clk);
    chk("bad_op_resp", 32'(tx_q[0]), 32'h3F);
    chk("bad_op_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
    clear_tx();
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    wait_tx(3, "rd2_resp_wait");
    wait_idle("rd2_idle_wait");
    chk("rd2_count", 32'(rd_cnt - r0), 32'd1);
    chk("rd2_idx", 32'(rd_idx), 32'h001);
    chk("rd2_b0", 32'(tx_q[0]), 32'h44);
    chk("rd2_b1", 32'(tx_q[1]), 32'hC0);
    chk("rd2_b2", 32'(tx_q[2]), 32'hDE);

    // Framing error byte is discarded
    clear_tx(); w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h57, 1'b0);
    repeat (12) @(negedge clk);
    chk("frm_active", 32'(bridge_active_o), 32'd0);
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    wait_tx(1, "frm_resp_wait");
    wait_idle("frm_idle_wait");
    chk("frm_count", 32'(wr_cnt - w0), 32'd1);
    chk("frm_idx", 32'(wr_idx), 32'h000);
    chk("frm_val", 32'(wr_val), 32'h0001);
    chk("frm_resp", 32'(tx_q[0]), 32'h4B);

    // Reset in the middle of the VH byte
    clear_tx(); w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    uart_rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_tx", 32'(uart_tx_o), 32'd1);
    chk("mid_rst_active", 32'(bridge_active_o), 32'd0);
    chk("mid_rst_idx", 32'(register_index_o), 32'h000);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("mid_rst_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
    chk("mid_rst_no_tx", 32'(tx_q.size()), 32'd0);
    send_byte(8'h57, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'hBC, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    wait_tx(1, "post_rst_wait");
    wait_idle("post_rst_idle_wait");
    chk("post_rst_count", 32'(wr_cnt - w0), 32'd1);
    chk("post_rst_idx", 32'(wr_idx), 32'hABC);
    chk("post_rst_val", 32'(wr_val), 32'h1234);
    chk("post_rst_resp", 32'(tx_q[0]), 32'h4B);
    chk("never_both", 32'(both_cnt), 32'd0);

    // Partial command followed by silence
    clear_tx(); w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h57, 1'b1); send_byte(8'h01, 1'b1);
    repeat (400) @(negedge clk);
    chk("to_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    chk("to_tx_count", 32'(tx_q.size()), 32'd1);
    chk("to_resp", 32'(tx_q[0]), 32'h54);
    chk("to_active", 32'(bridge_active_o), 32'd0);
`else
    chk("to_tx_count", 32'(tx_q.size()), 32'd0);
    chk("to_active", 32'(bridge_active_o), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
